// File: rtl/sampler_dma_pkg.sv
// Shared types and bit positions for the sampler DMA burst scheduler.
// Register-file control/status words are decoded with the indices below.
package sampler_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_REQ,
    ST_WAIT,
    ST_UPDATE
  } sched_state_e;

  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_LEN_LSB = 16;

  localparam int STAT_ACTIVE  = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_REM_LSB = 16;

  function automatic logic [31:0] pack_status(input logic active, input logic done,
                                              input logic err, input logic [15:0] rem);
    logic [31:0] s;
    s = '0;
    s[STAT_ACTIVE] = active;
    s[STAT_DONE]   = done;
    s[STAT_ERR]    = err;
    s[STAT_REM_LSB +: 16] = rem;
    return s;
  endfunction

endpackage

// File: rtl/sampler_rr_arbiter.sv
// Combinational round-robin pick: searches last_grant+1, +2, ... modulo N
// and reports the first requesting index.
module sampler_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  int idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[IW'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sampler_dma_scheduler.sv
// Per-voice sample fetch sequencer: arbitrates ready voices round-robin and
// issues one fixed-length read burst at a time to the AXI read master.
module sampler_dma_scheduler
  import sampler_dma_pkg::*;
#(
  parameter int MAX_VOICES  = 4,
  parameter int BURST_BEATS = 16,
  localparam int VOICE_W = $clog2(MAX_VOICES)
) (
  input  logic                         axi_clk,
  input  logic                         axi_reset,
  input  logic [MAX_VOICES-1:0][31:0]  dma_control,
  input  logic [MAX_VOICES-1:0][31:0]  dma_base_addr,
  output logic [MAX_VOICES-1:0][31:0]  dma_status,
  output logic [MAX_VOICES-1:0][31:0]  dma_curr_addr,
  input  logic [MAX_VOICES-1:0]        voice_data_req,
  output logic                         dma_req_valid,
  input  logic                         dma_req_ready,
  output logic [31:0]                  dma_req_addr,
  output logic [7:0]                   dma_req_len,
  output logic [VOICE_W-1:0]           dma_req_voice,
  input  logic                         dma_burst_done,
  input  logic                         dma_burst_err
);

  localparam logic [31:0] BURST_STRIDE = 32'(BURST_BEATS * 4);
  localparam logic [7:0]  REQ_LEN      = 8'(BURST_BEATS - 1);

  logic [MAX_VOICES-1:0][31:0] curr_addr_q;
  logic [MAX_VOICES-1:0][15:0] remaining_q;
  logic [MAX_VOICES-1:0]       active_q;
  logic [MAX_VOICES-1:0]       done_q;
  logic [MAX_VOICES-1:0]       err_q;
  logic [MAX_VOICES-1:0]       start_prev_q;

  logic [MAX_VOICES-1:0]       start_edge;
  logic [MAX_VOICES-1:0]       stop;
  logic [MAX_VOICES-1:0]       eligible;
  logic                        unused_ctrl_bits;

  sched_state_e                state_q;
  logic [VOICE_W-1:0]          winner_q;
  logic [VOICE_W-1:0]          rr_ptr_q;
  logic                        burst_err_q;

  logic                        grant_valid;
  logic [VOICE_W-1:0]          grant_idx;

  always_comb begin
    start_edge       = '0;
    stop             = '0;
    eligible         = '0;
    unused_ctrl_bits = 1'b0;
    for (int v = 0; v < MAX_VOICES; v++) begin
      start_edge[v]    = dma_control[v][CTRL_START] & ~start_prev_q[v];
      stop[v]          = dma_control[v][CTRL_STOP];
      eligible[v]      = active_q[v] & voice_data_req[v] & ~stop[v] & (remaining_q[v] != 16'd0);
      unused_ctrl_bits = unused_ctrl_bits ^ (^dma_control[v][15:2]);
    end
  end

  always_comb begin
    for (int v = 0; v < MAX_VOICES; v++) begin
      dma_status[v]    = pack_status(active_q[v], done_q[v], err_q[v], remaining_q[v]);
      dma_curr_addr[v] = curr_addr_q[v];
    end
  end

  sampler_rr_arbiter #(.N(MAX_VOICES)) u_arbiter (
    .req         (eligible),
    .last_grant  (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Per-voice state. Later assignments win: burst completion first, then
  // STOP / START, so a STOP during the owning burst still leaves the voice idle.
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      curr_addr_q  <= '0;
      remaining_q  <= '0;
      active_q     <= '0;
      done_q       <= '0;
      err_q        <= '0;
      start_prev_q <= '0;
    end else begin
      for (int v = 0; v < MAX_VOICES; v++) begin
        start_prev_q[v] <= dma_control[v][CTRL_START];

        if (state_q == ST_UPDATE && winner_q == VOICE_W'(v)) begin
          if (burst_err_q) begin
            active_q[v] <= 1'b0;
            err_q[v]    <= 1'b1;
          end else if (remaining_q[v] != 16'd0) begin
            curr_addr_q[v] <= curr_addr_q[v] + BURST_STRIDE;
            remaining_q[v] <= remaining_q[v] - 16'd1;
            if (remaining_q[v] == 16'd1) begin
              active_q[v] <= 1'b0;
              done_q[v]   <= 1'b1;
            end
          end
        end

        if (stop[v]) begin
          active_q[v] <= 1'b0;
        end else if (start_edge[v] && !active_q[v]) begin
          curr_addr_q[v] <= dma_base_addr[v];
          remaining_q[v] <= dma_control[v][CTRL_LEN_LSB +: 16];
          err_q[v]       <= 1'b0;
          if (dma_control[v][CTRL_LEN_LSB +: 16] == 16'd0) begin
            active_q[v] <= 1'b0;
            done_q[v]   <= 1'b1;
          end else begin
            active_q[v] <= 1'b1;
            done_q[v]   <= 1'b0;
          end
        end
      end
    end
  end

  // Burst sequencer. The RR pointer only moves in UPDATE so a committed grant
  // is never re-arbitrated while its burst is in flight.
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      state_q       <= ST_IDLE;
      winner_q      <= '0;
      rr_ptr_q      <= VOICE_W'(MAX_VOICES - 1);
      burst_err_q   <= 1'b0;
      dma_req_valid <= 1'b0;
      dma_req_addr  <= '0;
      dma_req_len   <= '0;
      dma_req_voice <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            winner_q <= grant_idx;
            state_q  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          dma_req_addr  <= curr_addr_q[winner_q];
          dma_req_voice <= winner_q;
          dma_req_len   <= REQ_LEN;
          dma_req_valid <= 1'b1;
          state_q       <= ST_REQ;
        end
        ST_REQ: begin
          if (dma_req_ready) begin
            dma_req_valid <= 1'b0;
            state_q       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dma_burst_done) begin
            burst_err_q <= dma_burst_err;
            state_q     <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          rr_ptr_q <= winner_q;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sampler_dma_scheduler.sv
// Directed bench for the sampler DMA scheduler with a small read-master responder.
module tb_sampler_dma_scheduler;

  logic             clk;
  logic             rst_n;
  logic [3:0][31:0] dma_control;
  logic [3:0][31:0] dma_base_addr;
  logic [3:0][31:0] dma_status;
  logic [3:0][31:0] dma_curr_addr;
  logic [3:0]       voice_data_req;
  logic             dma_req_valid;
  logic             dma_req_ready;
  logic [31:0]      dma_req_addr;
  logic [7:0]       dma_req_len;
  logic [1:0]       dma_req_voice;
  logic             dma_burst_done;
  logic             dma_burst_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sampler_dma_scheduler #(.MAX_VOICES(4), .BURST_BEATS(16)) dut (
    .axi_clk        (clk),
    .axi_reset      (rst_n),
    .dma_control    (dma_control),
    .dma_base_addr  (dma_base_addr),
    .dma_status     (dma_status),
    .dma_curr_addr  (dma_curr_addr),
    .voice_data_req (voice_data_req),
    .dma_req_valid  (dma_req_valid),
    .dma_req_ready  (dma_req_ready),
    .dma_req_addr   (dma_req_addr),
    .dma_req_len    (dma_req_len),
    .dma_req_voice  (dma_req_voice),
    .dma_burst_done (dma_burst_done),
    .dma_burst_err  (dma_burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n          = 1'b0;
    dma_control    = '0;
    dma_base_addr  = '0;
    voice_data_req = '0;
    dma_req_ready  = 1'b0;
    dma_burst_done = 1'b0;
    dma_burst_err  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_voice(input int v, input logic [31:0] base, input logic [15:0] len);
    dma_base_addr[v] = base;
    dma_control[v]   = {len, 16'h0000};
  endtask

  task automatic start_voices(input logic [3:0] mask);
    for (int v = 0; v < 4; v++) if (mask[v]) dma_control[v][0] = 1'b1;
    @(negedge clk);
    for (int v = 0; v < 4; v++) dma_control[v][0] = 1'b0;
  endtask

  task automatic wait_valid(output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    while (dma_req_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout = 1'b1;
  endtask

  task automatic pulse_done(input logic err);
    dma_burst_done = 1'b1;
    dma_burst_err  = err;
    @(negedge clk);
    dma_burst_done = 1'b0;
    dma_burst_err  = 1'b0;
  endtask

  task automatic handshake();
    dma_req_ready = 1'b1;
    @(negedge clk);
    dma_req_ready = 1'b0;
  endtask

  task automatic do_burst(input logic err, output logic [31:0] addr, output logic [1:0] voice,
                          output logic [7:0] len, output bit timeout);
    wait_valid(timeout);
    addr  = dma_req_addr;
    voice = dma_req_voice;
    len   = dma_req_len;
    if (timeout) return;
    handshake();
    repeat (2) @(negedge clk);
    pulse_done(err);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({dma_req_valid, dma_req_addr, dma_req_len, dma_req_voice} !== 43'd0)
      $display("[TB] FAIL reset_req: got %h, expected 0", {dma_req_valid, dma_req_addr, dma_req_len, dma_req_voice});
    else pass_cnt++;
    total_cnt++;
    if ({dma_status, dma_curr_addr} !== 256'd0)
      $display("[TB] FAIL reset_regs: got %h, expected 0", {dma_status, dma_curr_addr});
    else pass_cnt++;
  endtask

  task automatic test_single_voice();
    logic [31:0] a; logic [1:0] vc; logic [7:0] ln; bit to;
    do_reset();
    set_voice(0, 32'h1000, 16'd2);
    voice_data_req = 4'b0001;
    start_voices(4'b0001);
    total_cnt++;
    if (dma_status[0] !== 32'h0002_0001) $display("[TB] FAIL single_start_status: got %h, expected %h", dma_status[0], 32'h0002_0001);
    else pass_cnt++;
    total_cnt++;
    if (dma_curr_addr[0] !== 32'h1000) $display("[TB] FAIL single_start_addr: got %h, expected %h", dma_curr_addr[0], 32'h1000);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (dma_req_valid !== 1'b0) $display("[TB] FAIL latency_early: got %b, expected 0", dma_req_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (dma_req_valid !== 1'b1) $display("[TB] FAIL latency_valid: got %b, expected 1", dma_req_valid);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      do_burst(1'b0, a, vc, ln, to);
      total_cnt++;
      if (to !== 1'b0) $display("[TB] FAIL single_timeout: got %b, expected 0", to);
      else pass_cnt++;
      total_cnt++;
      if ({a, vc, ln} !== {32'h1000 + 32'(i * 64), 2'd0, 8'd15})
        $display("[TB] FAIL single_burst%0d: got %h, expected %h", i, {a, vc, ln}, {32'h1000 + 32'(i * 64), 2'd0, 8'd15});
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (dma_status[0] !== 32'h0000_0002) $display("[TB] FAIL single_done_status: got %h, expected %h", dma_status[0], 32'h2);
    else pass_cnt++;
    total_cnt++;
    if (dma_curr_addr[0] !== 32'h1080) $display("[TB] FAIL single_done_addr: got %h, expected %h", dma_curr_addr[0], 32'h1080);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    logic [31:0] a; logic [1:0] vc; logic [7:0] ln; bit to;
    logic [31:0] base [4];
    do_reset();
    base[0] = 32'h0001_0000; base[1] = 32'h0002_0000;
    base[2] = 32'h0003_0000; base[3] = 32'h0004_0000;
    for (int v = 0; v < 4; v++) set_voice(v, base[v], 16'd3);
    voice_data_req = 4'b1111;
    start_voices(4'b1111);
    for (int i = 0; i < 12; i++) begin
      do_burst(1'b0, a, vc, ln, to);
      total_cnt++;
      if (to !== 1'b0) $display("[TB] FAIL fair_timeout%0d: got %b, expected 0", i, to);
      else pass_cnt++;
      total_cnt++;
      if (vc !== 2'(i % 4)) $display("[TB] FAIL fair_voice%0d: got %0d, expected %0d", i, vc, i % 4);
      else pass_cnt++;
      total_cnt++;
      if (a !== base[i % 4] + 32'((i / 4) * 64)) $display("[TB] FAIL fair_addr%0d: got %h, expected %h", i, a, base[i % 4] + 32'((i / 4) * 64));
      else pass_cnt++;
    end
    @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      total_cnt++;
      if ({dma_status[v], dma_curr_addr[v]} !== {32'h2, base[v] + 32'hC0})
        $display("[TB] FAIL fair_final%0d: got %h, expected %h", v, {dma_status[v], dma_curr_addr[v]}, {32'h2, base[v] + 32'hC0});
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    bit to; int highs;
    do_reset();
    set_voice(2, 32'h2000, 16'd1);
    voice_data_req = 4'b0100;
    start_voices(4'b0100);
    wait_valid(to);
    total_cnt++;
    if (to !== 1'b0) $display("[TB] FAIL bp_timeout: got %b, expected 0", to);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({dma_req_valid, dma_req_addr, dma_req_voice} !== {1'b1, 32'h2000, 2'd2})
        $display("[TB] FAIL bp_stable%0d: got %h, expected %h", i, {dma_req_valid, dma_req_addr, dma_req_voice}, {1'b1, 32'h2000, 2'd2});
      else pass_cnt++;
    end
    handshake();
    total_cnt++;
    if (dma_req_valid !== 1'b0) $display("[TB] FAIL bp_drop: got %b, expected 0", dma_req_valid);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    pulse_done(1'b0);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (dma_req_valid === 1'b1) highs++;
      @(negedge clk);
    end
    total_cnt++;
    if (highs !== 0) $display("[TB] FAIL bp_one_burst: got %0d extra valid cycles, expected 0", highs);
    else pass_cnt++;
    total_cnt++;
    if (dma_status[2] !== 32'h2) $display("[TB] FAIL bp_status: got %h, expected %h", dma_status[2], 32'h2);
    else pass_cnt++;
  endtask

  task automatic test_error();
    logic [31:0] a; logic [1:0] vc; logic [7:0] ln; bit to;
    do_reset();
    set_voice(1, 32'h3000, 16'd2);
    set_voice(2, 32'h4000, 16'd1);
    voice_data_req = 4'b0110;
    start_voices(4'b0110);
    do_burst(1'b1, a, vc, ln, to);
    total_cnt++;
    if ({to, a, vc} !== {1'b0, 32'h3000, 2'd1}) $display("[TB] FAIL err_burst: got %h, expected %h", {to, a, vc}, {1'b0, 32'h3000, 2'd1});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (dma_status[1] !== 32'h0002_0004) $display("[TB] FAIL err_status: got %h, expected %h", dma_status[1], 32'h0002_0004);
    else pass_cnt++;
    total_cnt++;
    if (dma_curr_addr[1] !== 32'h3000) $display("[TB] FAIL err_addr: got %h, expected %h", dma_curr_addr[1], 32'h3000);
    else pass_cnt++;
    do_burst(1'b0, a, vc, ln, to);
    total_cnt++;
    if ({to, a, vc} !== {1'b0, 32'h4000, 2'd2}) $display("[TB] FAIL err_next_voice: got %h, expected %h", {to, a, vc}, {1'b0, 32'h4000, 2'd2});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({dma_status[2], dma_status[1]} !== {32'h2, 32'h0002_0004})
      $display("[TB] FAIL err_final: got %h, expected %h", {dma_status[2], dma_status[1]}, {32'h2, 32'h0002_0004});
    else pass_cnt++;
  endtask

  task automatic test_stop_in_wait();
    bit to; int highs;
    do_reset();
    set_voice(0, 32'h5000, 16'd4);
    voice_data_req = 4'b0001;
    start_voices(4'b0001);
    wait_valid(to);
    total_cnt++;
    if ({to, dma_req_addr} !== {1'b0, 32'h5000}) $display("[TB] FAIL stop_req: got %h, expected %h", {to, dma_req_addr}, {1'b0, 32'h5000});
    else pass_cnt++;
    handshake();
    dma_control[0][1] = 1'b1;
    repeat (2) @(negedge clk);
    pulse_done(1'b0);
    @(negedge clk);
    total_cnt++;
    if (dma_status[0] !== 32'h0003_0000) $display("[TB] FAIL stop_status: got %h, expected %h", dma_status[0], 32'h0003_0000);
    else pass_cnt++;
    total_cnt++;
    if (dma_curr_addr[0] !== 32'h5040) $display("[TB] FAIL stop_addr: got %h, expected %h", dma_curr_addr[0], 32'h5040);
    else pass_cnt++;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dma_req_valid === 1'b1) highs++;
    end
    total_cnt++;
    if (highs !== 0) $display("[TB] FAIL stop_no_grant: got %0d valid cycles, expected 0", highs);
    else pass_cnt++;
  endtask

  task automatic test_edges();
    logic [31:0] a; logic [1:0] vc; logic [7:0] ln; bit to; int highs;
    do_reset();
    set_voice(3, 32'hFFFF_FFC0, 16'd2);
    voice_data_req = 4'b1000;
    start_voices(4'b1000);
    do_burst(1'b0, a, vc, ln, to);
    total_cnt++;
    if ({to, a, vc} !== {1'b0, 32'hFFFF_FFC0, 2'd3}) $display("[TB] FAIL wrap_first: got %h, expected %h", {to, a, vc}, {1'b0, 32'hFFFF_FFC0, 2'd3});
    else pass_cnt++;
    do_burst(1'b0, a, vc, ln, to);
    total_cnt++;
    if ({to, a} !== {1'b0, 32'h0}) $display("[TB] FAIL wrap_second: got %h, expected %h", {to, a}, {1'b0, 32'h0});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({dma_status[3], dma_curr_addr[3]} !== {32'h2, 32'h40}) $display("[TB] FAIL wrap_final: got %h, expected %h", {dma_status[3], dma_curr_addr[3]}, {32'h2, 32'h40});
    else pass_cnt++;

    do_reset();
    set_voice(1, 32'h7000, 16'd0);
    voice_data_req = 4'b1111;
    start_voices(4'b0010);
    total_cnt++;
    if ({dma_status[1], dma_curr_addr[1]} !== {32'h2, 32'h7000}) $display("[TB] FAIL len0_status: got %h, expected %h", {dma_status[1], dma_curr_addr[1]}, {32'h2, 32'h7000});
    else pass_cnt++;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dma_req_valid === 1'b1) highs++;
    end
    total_cnt++;
    if (highs !== 0) $display("[TB] FAIL len0_no_req: got %0d valid cycles, expected 0", highs);
    else pass_cnt++;

    do_reset();
    set_voice(0, 32'h6000, 16'd2);
    voice_data_req = 4'b0001;
    start_voices(4'b0001);
    wait_valid(to);
    handshake();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({to, dma_req_valid, dma_req_addr, dma_req_len, dma_req_voice} !== 44'd0)
      $display("[TB] FAIL rst_wait_req: got %h, expected 0", {to, dma_req_valid, dma_req_addr, dma_req_len, dma_req_voice});
    else pass_cnt++;
    total_cnt++;
    if ({dma_status[0], dma_curr_addr[0]} !== 64'd0) $display("[TB] FAIL rst_wait_regs: got %h, expected 0", {dma_status[0], dma_curr_addr[0]});
    else pass_cnt++;
    dma_control = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_done(1'b0);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dma_req_valid === 1'b1) highs++;
    end
    total_cnt++;
    if ({highs[7:0], dma_status[0]} !== 40'd0) $display("[TB] FAIL late_done: got %h, expected 0", {highs[7:0], dma_status[0]});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_voice();
    test_fairness();
    test_backpressure();
    test_error();
    test_stop_in_wait();
    test_edges();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
